// File: rtl/load_unit_if.sv
// Load unit bus bundle: decode request, data-memory read channel, writeback.
// master = load unit side, slave = decoder/memory/writeback side.
interface load_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] rs1_data;
  logic [11:0]       imm;
  logic [4:0]        rd;
  logic [2:0]        load_control;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              ld_misalign;
  logic              ld_err;

  modport master (
    input  ld_valid, rs1_data, imm, rd, load_control,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output ld_ready, mem_req, mem_addr,
    output wb_valid, wb_rd, wb_data,
    output ld_misalign, ld_err
  );

  modport slave (
    output ld_valid, rs1_data, imm, rd, load_control,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  ld_ready, mem_req, mem_addr,
    input  wb_valid, wb_rd, wb_data,
    input  ld_misalign, ld_err
  );
endinterface

// File: rtl/load_unit.sv
// load_unit: RV32 load execution (LB/LH/LW/LBU/LHU), one load in flight.
// Ports: clk, rst_n (async low), bus (load_unit_if.master). Option: LOAD_TIMEOUT_EN.
`ifndef LB
`define LB     3'b000
`define LH     3'b001
`define LW     3'b010
`define LBU    3'b100
`define LHU    3'b101
`define LD_NOP 3'b111
`endif

module load_unit #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic          clk,
  input logic          rst_n,
  load_unit_if.master  bus
);
  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, RESP
  } state_t;

  state_t r_state, w_next;

  logic [1:0]        r_off;
  logic [4:0]        r_rd;
  logic [2:0]        r_ctrl;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_mis;
  logic              r_err;

  logic [ADDR_W-1:0] w_ea;
  logic              w_accept;
  logic              w_mem_op;
  logic              w_mis;
  logic              w_go;
  logic              w_load;
  logic              w_timeout;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_ext;

  assign w_ea = bus.rs1_data
              + {{(ADDR_W-12){bus.imm[11]}}, bus.imm};
  assign w_accept = bus.ld_valid && (r_state == IDLE);
  assign w_go = w_accept && w_mem_op && !w_mis;

  always_comb begin
    w_mem_op = 1'b0;
    w_mis    = 1'b0;
    case (bus.load_control)
      `LB, `LBU: w_mem_op = 1'b1;
      `LH, `LHU: begin
        w_mem_op = 1'b1;
        w_mis    = w_ea[0];
      end
      `LW: begin
        w_mem_op = 1'b1;
        w_mis    = |w_ea[1:0];
      end
      default: ;
    endcase
  end

  // rvalid together with gnt completes the read without visiting WAIT
  assign w_load =
    ((r_state == REQ) && bus.mem_gnt && bus.mem_rvalid) ||
    ((r_state == WAIT) && bus.mem_rvalid);

`ifdef LOAD_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 255)
                    ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (r_state != WAIT)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
  end

  assign w_timeout = (r_state == WAIT) &&
                     !bus.mem_rvalid && (r_cnt == LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_go) w_next = REQ;
      REQ:
        if (bus.mem_gnt)
          w_next = bus.mem_rvalid ? RESP : WAIT;
      WAIT:
        if (bus.mem_rvalid)  w_next = RESP;
        else if (w_timeout)  w_next = IDLE;
      RESP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    case (r_off)
      2'd0: w_byte = bus.mem_rdata[7:0];
      2'd1: w_byte = bus.mem_rdata[15:8];
      2'd2: w_byte = bus.mem_rdata[23:16];
      2'd3: w_byte = bus.mem_rdata[31:24];
      default: ;
    endcase
    w_half = r_off[1] ? bus.mem_rdata[31:16]
                      : bus.mem_rdata[15:0];
    case (r_ctrl)
      `LB:  w_ext = {{(DATA_W-8){w_byte[7]}}, w_byte};
      `LBU: w_ext = {{(DATA_W-8){1'b0}}, w_byte};
      `LH:  w_ext = {{(DATA_W-16){w_half[15]}}, w_half};
      `LHU: w_ext = {{(DATA_W-16){1'b0}}, w_half};
      default: w_ext = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_off     <= '0;
      r_rd      <= '0;
      r_ctrl    <= '0;
      r_addr    <= '0;
      r_wb_data <= '0;
      r_mis     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_mis <= w_accept && w_mem_op && w_mis;
      r_err <= w_timeout;
      if (w_go) begin
        r_off  <= w_ea[1:0];
        r_rd   <= bus.rd;
        r_ctrl <= bus.load_control;
        r_addr <= {w_ea[ADDR_W-1:2], 2'b00};
      end
      if (w_load)
        r_wb_data <= w_ext;
    end
  end

  assign bus.ld_ready    = (r_state == IDLE);
  assign bus.mem_req     = (r_state == REQ);
  assign bus.mem_addr    = r_addr;
  assign bus.wb_valid    = (r_state == RESP);
  assign bus.wb_rd       = r_rd;
  assign bus.wb_data     = r_wb_data;
  assign bus.ld_misalign = r_mis;
  assign bus.ld_err      = r_err;
endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Executes the loads produced by the load-instruction decoder.
- Takes the decoded rs1 value, the 12-bit imm, rd and load_control.
- Computes the effective address and issues one word read on the data-memory request/response interface.
- Extracts the byte or halfword, sign- or zero-extends it, and returns the result to register writeback. One load in flight at a time.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, memory word and register width (fixed at 32 for RV32)
TIMEOUT_CYCLES, 255, maximum wait for mem_rvalid when the optional feature is compiled in

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ld_valid  in  1  load request from decode
ld_ready  out  1  unit can accept a load (high only in IDLE)
rs1_data  in  32  base register value
imm  in  12  signed offset
rd  in  5  destination register
load_control  in  3  load type: `LB/`LH/`LW/`LBU/`LHU/`LD_NOP from processor_defines
mem_req  out  1  read request
mem_addr  out  32  word-aligned address ({ea[31:2],2'b00})
mem_gnt  in  1  memory accepts request
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word
wb_valid  out  1  one-cycle writeback strobe
wb_rd  out  5  destination register
wb_data  out  32  extended load result
ld_misalign  out  1  one-cycle misaligned-address exception strobe
ld_err  out  1  one-cycle bus-timeout strobe (always 0 without the optional feature)

Behaviour:
- Reset (async, rst_n=0) puts the unit in IDLE. Output values:
  - ld_ready=1; mem_req=0; mem_addr=0; wb_valid=0; wb_rd=0; wb_data=0; ld_misalign=0; ld_err=0.
  - All captured operands clear.
- Reset mid-transaction aborts immediately; no writeback is produced for the aborted load.
- Effective address: ea = rs1_data + sign_extend(imm), modulo 2^32 (wrap-around silent).
- Accept happens on ld_valid && ld_ready. The unit captures ea[1:0], rd and load_control at that edge.
- `LD_NOP: accepted, unit stays in IDLE, no memory access, no strobe.
- Misalignment check at accept:
  - LH/LHU with ea[0]=1 → misaligned.
  - LW with ea[1:0]!=0 → misaligned.
  - Response: ld_misalign=1 for exactly the next cycle, no mem_req, no wb_valid, return to IDLE.
- States:
  - IDLE: ld_ready=1. On an aligned accept go to REQ; mem_req rises the cycle after accept.
  - REQ: mem_req=1 and mem_addr stay stable until mem_gnt=1. On the mem_gnt edge go to WAIT and drop mem_req. mem_rvalid in the same cycle as mem_gnt is legal; treat it as WAIT completing and go straight to RESP.
  - WAIT: hold until mem_rvalid=1. Latch mem_rdata, go to RESP.
  - RESP: wb_valid=1 for exactly one cycle with wb_rd and wb_data. Next state is IDLE.
- Minimum latency: accept to wb_valid = 3 cycles, with mem_gnt and mem_rvalid both high in the cycle after mem_req rises.
- Extraction by off = ea[1:0]:
  - Byte = rdata[8*off+7 : 8*off].
  - Half = rdata[16*off[1]+15 : 16*off[1]].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word through.
- mem_rvalid outside WAIT/REQ is ignored.
- ld_ready=0 in REQ, WAIT and RESP; ld_valid is ignored there.

Optional Feature:
- Macro: LOAD_TIMEOUT_EN.
- When defined:
  - An 8-bit-or-wider counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without mem_rvalid, ld_err=1 for one cycle, no wb_valid, return to IDLE.
  - A late mem_rvalid arriving after this is ignored.
- When undefined: no counter, WAIT waits indefinitely, ld_err is tied to 0.

Test Plan:
- Reset then idle: all outputs at reset values and ld_ready=1. Assert rst_n=0 during WAIT → immediate IDLE, no wb_valid after release.
- LW, rs1_data=0x1000, imm=0x004, mem_rdata=0xDEADBEEF, gnt and rvalid immediate → mem_addr=0x1004; wb_valid 3 cycles after accept; wb_data=0xDEADBEEF.
- LB at ea=0x2003, mem_rdata=0x80112233 → wb_data=0xFFFFFF80. LBU at the same address → 0x00000080.
- LH at ea=0x3002, rdata=0x8001FFFF → 0xFFFF8001. LHU imm=0xFFE (−2), rs1_data=0x3004 → ea=0x3002, 0x00008001.
- LW at ea=0x4001 and LH at ea=0x4003 → ld_misalign pulse each, mem_req never asserted. `LD_NOP → no activity.
- mem_gnt delayed 4 cycles and rvalid 5 cycles → mem_addr stable throughout REQ, single wb_valid. With LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=8 and no rvalid → ld_err pulse after 8 WAIT cycles, then ld_ready=1.
